// File: rtl/mem_hazard_ctrl.sv
// rtl/mem_hazard_ctrl.sv - pipeline suspend/flush control, MEM data-bus handshake with watchdog, LL/SC link bit
module mem_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       cpu_clk,
  input  logic       cpu_rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_wR,
  input  logic       ex_branch_taken,
  input  logic       mem_valid,
  input  logic       mem_access,
  input  logic       mem_is_ll,
  input  logic       mem_is_sc,
  input  logic       ll_clear,
  input  logic       dbus_gnt,
  input  logic       dbus_rdy,
  output logic       dbus_req,
  output logic       suspend_if,
  output logic       suspend_id,
  output logic       suspend_ex,
  output logic       suspend_mem,
  output logic       flush_if,
  output logic       flush_id,
  output logic       mem_done,
  output logic       sc_success,
  output logic       llbit,
  output logic       bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sc_ok, sc_ok_nxt;
  logic             aborted, aborted_nxt;
  logic             llbit_nxt;
  logic             acc, mem_stall, timeout, lu;

  assign acc       = mem_valid & mem_access;
  assign mem_stall = acc & (state != DONE);
  assign timeout   = (cnt == CNT_W'(TIMEOUT));
  assign lu        = ex_valid & ex_is_load & (ex_wR != 5'd0) &
                     ((id_rs_used & (id_rs == ex_wR)) | (id_rt_used & (id_rt == ex_wR)));

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sc_ok   <= 1'b0;
      aborted <= 1'b0;
      llbit   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sc_ok   <= sc_ok_nxt;
      aborted <= aborted_nxt;
      llbit   <= llbit_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sc_ok_nxt   = sc_ok;
    aborted_nxt = aborted;
    dbus_req    = 1'b0;
    mem_done    = 1'b0;
    sc_success  = 1'b0;
    bus_err     = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          aborted_nxt = 1'b0;
          if (mem_is_sc && !llbit) begin
            // SC without a link cannot succeed, so skip the bus entirely
            sc_ok_nxt = 1'b0;
            state_nxt = DONE;
          end else begin
            sc_ok_nxt = llbit;
            cnt_nxt   = '0;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (dbus_gnt && dbus_rdy) begin
          dbus_req  = 1'b1;
          state_nxt = DONE;
        end else if (timeout) begin
          bus_err     = 1'b1;
          aborted_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          dbus_req = 1'b1;
          if (dbus_gnt) state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (dbus_rdy) begin
          state_nxt = DONE;
        end else if (timeout) begin
          bus_err     = 1'b1;
          aborted_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        mem_done   = 1'b1;
        sc_success = sc_ok & mem_is_sc;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ll_clear wins over a completing LL in the same cycle
  always_comb begin
    llbit_nxt = llbit;
    if (state == DONE) begin
      if (mem_is_sc)                 llbit_nxt = 1'b0;
      else if (mem_is_ll && !aborted) llbit_nxt = 1'b1;
    end
    if (ll_clear) llbit_nxt = 1'b0;
  end

  always_comb begin
    suspend_if  = 1'b0;
    suspend_id  = 1'b0;
    suspend_ex  = 1'b0;
    suspend_mem = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    if (mem_stall) begin
      suspend_if  = 1'b1;
      suspend_id  = 1'b1;
      suspend_ex  = 1'b1;
      suspend_mem = 1'b1;
    end else if (ex_branch_taken) begin
      // the ID instruction is wrong-path, so a pending load-use stall is moot
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (lu) begin
      suspend_if = 1'b1;
      suspend_id = 1'b1;
      flush_id   = 1'b1;
    end
  end

endmodule

// File: doc/mem_hazard_ctrl.md
Name: mem_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Generates per-stage suspend and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Runs the MEM-stage data-bus handshake as a state machine with a timeout watchdog.
- Holds the LL/SC link bit and resolves SC success.

Parameters:
- TIMEOUT, 255: max cycles in REQ+WAIT before the access is aborted.
- CNT_W, 8: watchdog counter width; TIMEOUT must be < 2^CNT_W.

Ports:
- cpu_clk  in  1  core clock; all state on rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  ID-stage source register 1.
- id_rt  in  5  ID-stage source register 2.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load (includes LL).
- ex_wR  in  5  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_access  in  1  MEM instruction is a load or store.
- mem_is_ll  in  1  MEM instruction is LL.
- mem_is_sc  in  1  MEM instruction is SC.
- ll_clear  in  1  exception/ERET: clears link bit.
- dbus_gnt  in  1  bus accepted the request.
- dbus_rdy  in  1  bus completed the transfer.
- dbus_req  out  1  bus request.
- suspend_if  out  1  hold PC and IF/ID.
- suspend_id  out  1  hold ID/EX.
- suspend_ex  out  1  hold EX/MEM.
- suspend_mem  out  1  hold MEM/WB.
- flush_if  out  1  load bubble into IF/ID (valid=0).
- flush_id  out  1  load bubble into ID/EX.
- mem_done  out  1  MEM access completes this cycle.
- sc_success  out  1  SC result value; meaningful while mem_done.
- llbit  out  1  link bit.
- bus_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async): FSM=IDLE, cnt=0, llbit=0, sc_ok=0. dbus_req, mem_done, bus_err and sc_success are 0 in IDLE.
- Definitions:
  - acc = mem_valid & mem_access.
  - mem_stall = acc & (state != DONE).
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - acc & mem_is_sc & !llbit -> DONE. No bus request; sc_ok=0.
  - acc otherwise -> REQ; sc_ok=llbit; cnt=0.
- REQ:
  - dbus_req=1, held until dbus_gnt is sampled high.
  - gnt & rdy in the same cycle -> DONE.
  - gnt alone -> WAIT.
  - rdy without gnt is ignored.
- WAIT: dbus_req=0; rdy -> DONE.
- Watchdog: in REQ/WAIT, cnt increments each cycle. On the cycle cnt==TIMEOUT with no completion: bus_err=1 and -> DONE; that cycle's dbus_req=0.
- DONE:
  - Lasts exactly 1 cycle; mem_done=1; mem_stall=0, so the pipeline advances; then -> IDLE.
  - sc_success = sc_ok & mem_is_sc.
  - Back-to-back accesses: the next access starts in the IDLE cycle after DONE. Minimum access latency is 3 cycles (IDLE, REQ, DONE). Failed SC latency is 2 cycles (IDLE, DONE).
- Link bit (updated at the end of DONE):
  - Set if mem_is_ll and no bus_err.
  - Cleared if mem_is_sc (success or fail).
  - ll_clear clears in any cycle and has priority over set.
  - ll_clear during REQ/WAIT does not change the captured sc_ok.
- Load-use hazard: lu = ex_valid & ex_is_load & ex_wR!=0 & ((id_rs_used & id_rs==ex_wR) | (id_rt_used & id_rt==ex_wR)).
- Output priority (combinational):
  1. mem_stall: all four suspends = 1; flush_if = flush_id = 0.
  2. ex_branch_taken: flush_if = flush_id = 1; suspends = 0. Branch overrides lu because the ID instruction is wrong-path.
  3. lu: suspend_if = suspend_id = 1, flush_id = 1, suspend_ex = suspend_mem = 0.
  4. Otherwise all outputs = 0.
- Reset mid-transfer: FSM returns to IDLE and dbus_req drops immediately. The bus is expected to be reset by the same cpu_rst.

Test Plan:
- Load, gnt at cycle 2, rdy at cycle 4 after acc rises -> dbus_req high for cycles 1–2 (REQ); suspends 1 for cycles 0–4; mem_done=1 at cycle 5.
- LL then SC to completion, no ll_clear -> llbit=1 after LL DONE; SC DONE has sc_success=1; llbit=0 afterwards.
- SC with llbit=0 -> dbus_req never asserts; mem_done at cycle 1; sc_success=0.
- Load in EX writing r5; ID reads rt=r5 -> one cycle with suspend_if=suspend_id=flush_id=1. Same with ex_wR=0 -> no stall.
- Concurrent cases:
  - ex_branch_taken together with lu -> flush_if=flush_id=1, no suspend.
  - ex_branch_taken during mem_stall -> only suspends assert.
- TIMEOUT=4, dbus_gnt never asserts -> bus_err pulse 4 cycles after REQ entry; FSM reaches DONE then IDLE. Assert cpu_rst during WAIT -> dbus_req=0 and FSM=IDLE immediately.
